position_write_ctrl: RTL
========================

// Module: position_write_ctrl
// PURPOSE
//  Parametrised successor of the board position decoder: validates and arbitrates moves.
//  Decodes a move into a one-hot, single-cycle register write enable.
//  Tracks which cells are occupied and rejects illegal moves with a reason code.
//  Sits between the player/computer move sources and the per-cell board registers.
// PARAMETERS
//  NUM_POS  9  number of board cells; wr_en/occupied width; legal range 1..2**POS_W
//  POS_W    4  width of req_pos; elaboration error if 2**POS_W < NUM_POS
// PORTS
//  clock       in   1        single clock; all logic on rising edge
//  reset_n     in   1        synchronous, active-low reset
//  clear       in   1        synchronous board clear (new game), active-high
//  req_valid   in   1        move request present
//  req_ready   out  1        block can accept a request this cycle
//  req_pos     in   POS_W    cell index of requested move
//  req_player  in   1        0 = player, 1 = computer
//  wr_en       out  NUM_POS  one-hot cell write enable, 1-cycle pulse
//  wr_player   out  1        player owning the current wr_en pulse
//  illegal     out  1        1-cycle pulse: request rejected
//  illegal_code out 2        0 none, 1 out of range, 2 occupied/board full, 3 wrong turn
//  occupied    out  NUM_POS  occupancy map, bit i = cell i taken
//  move_count  out  POS_W+1  committed moves since reset/clear
//  board_full  out  1        move_count == NUM_POS
// BEHAVIOUR
//  - Reset (reset_n=0 at edge): state IDLE; wr_en, occupied, move_count=0;
//    illegal, illegal_code, wr_player=0. req_ready is 0 during reset, 1 in IDLE afterwards.
//  - FSM states: IDLE, COMMIT, REJECT, FULL. All outputs registered except req_ready = (state IDLE|FULL).
//  - IDLE: on req_valid&&req_ready at edge T:
//      req_pos >= NUM_POS               -> REJECT, code 1
//      occupied[req_pos]                -> REJECT, code 2
//      turn check failed (macro only)   -> REJECT, code 3
//      otherwise                        -> COMMIT
//    Priority is code 1 > 2 > 3.
//  - COMMIT (cycle T+1): wr_en = 1<<req_pos and wr_player = req_player; req_ready=0.
//    At the end of T+1: occupied bit set; move_count+1; next state FULL if the new count == NUM_POS, else IDLE.
//  - REJECT (cycle T+1): illegal=1 with code held; wr_en=0; board state unchanged; next IDLE.
//  - Accepted request latency: wr_en/illegal in the cycle after the accepting edge.
//    Max throughput is one request per 2 cycles.
//  - illegal_code is 0 whenever illegal=0.
//  - FULL: req_ready=1; any request -> REJECT code 2, which returns to FULL rather than IDLE.
//  - clear: highest priority after reset_n, in any state. Next state IDLE; occupied=0, move_count=0.
//    A COMMIT in progress still drives its wr_en pulse that cycle, but the occupancy update is dropped (clear wins).
//    A request presented in the same cycle as clear is not accepted (req_ready treated 0).
//  - Out-of-range or X-free decode: wr_en never has more than one bit set.
//  - move_count saturates at NUM_POS.
// CONFIGURATION
//  - POS_WRITE_TURN_CHECK_EN defined:
//    - Internal expected_player reg: 0 after reset/clear; toggles on each COMMIT.
//    - Request with req_player != expected_player -> REJECT code 3.
//  - Not defined:
//    - No expected_player reg.
//    - req_player is only forwarded to wr_player.
//    - Code 3 is never produced.
// TESTING
//  1. Reset, then req pos=4 player=0 -> next cycle wr_en=9'h010, wr_player=0;
//     following cycle occupied=9'h010, move_count=1.
//  2. Repeat pos=4 -> illegal=1, code=2, wr_en=0; occupied unchanged.
//  3. req pos=12 (NUM_POS=9) -> illegal=1, code=1; move_count unchanged.
//  4. Fill all 9 cells alternating players -> board_full=1, state FULL;
//     next req pos=0 -> code 2; then clear -> occupied=0, move_count=0, board_full=0.
//  5. clear asserted during COMMIT of pos=2 -> wr_en=9'h004 pulse seen; occupied=0 afterwards.
//  6. With POS_WRITE_TURN_CHECK_EN: first req player=1 -> code 3; player=0 then player=0 -> second gets code 3.
//     Without the macro, the same sequence commits.

Source files
------------

// File: rtl/position_write_ctrl.sv
// position_write_ctrl: validates board moves, arbitrates them and decodes each
// accepted move into a one-hot, single-cycle cell write enable. It also keeps
// the occupancy map and the count of committed moves.
// Optional feature: define POS_WRITE_TURN_CHECK_EN to enforce alternating turns
// (player 0 first). A request from the wrong side is rejected with code 3.
module position_write_ctrl #(
  parameter int NUM_POS = 9,
  parameter int POS_W   = 4
) (
  input  logic               clock,
  input  logic               reset_n,
  input  logic               clear,
  input  logic               req_valid,
  output logic               req_ready,
  input  logic [POS_W-1:0]   req_pos,
  input  logic               req_player,
  output logic [NUM_POS-1:0] wr_en,
  output logic               wr_player,
  output logic               illegal,
  output logic [1:0]         illegal_code,
  output logic [NUM_POS-1:0] occupied,
  output logic [POS_W:0]     move_count,
  output logic               board_full
);

  // Stop elaboration when the parameters cannot describe a legal board.
  if (NUM_POS < 1 || (2**POS_W) < NUM_POS) begin : g_param_chk
    $error("position_write_ctrl: need 1 <= NUM_POS <= 2**POS_W");
  end

  localparam logic [POS_W:0] FULL_CNT = (POS_W+1)'(NUM_POS);

  localparam logic [1:0] C_NONE  = 2'd0;
  localparam logic [1:0] C_RANGE = 2'd1;
  localparam logic [1:0] C_OCC   = 2'd2;
  localparam logic [1:0] C_TURN  = 2'd3;

  typedef enum logic [1:0] {IDLE, COMMIT, REJECT, FULL} state_t;

  // Every registered output lives in one struct. The next-state logic can
  // then start from "hold" and override only what changes.
  typedef struct packed {
    logic [NUM_POS-1:0] wr_en;
    logic               wr_player;
    logic               illegal;
    logic [1:0]         code;
    logic [NUM_POS-1:0] occupied;
    logic [POS_W:0]     count;
    logic               full;
  } regs_t;

  state_t state, nxt_state;
  regs_t  r, n;

  logic [NUM_POS-1:0] dec;
  logic               out_of_range;
  logic               accept;
  logic [POS_W:0]     cnt_inc;

`ifdef POS_WRITE_TURN_CHECK_EN
  logic exp_player, nxt_exp_player;
`endif

  // One comparator per cell. An out-of-range position matches no cell, so the
  // write enable can never carry more than one bit.
  for (genvar i = 0; i < NUM_POS; i++) begin : g_dec
    assign dec[i] = ({1'b0, req_pos} == (POS_W+1)'(i));
  end

  assign out_of_range = ({1'b0, req_pos} >= FULL_CNT);
  assign req_ready    = reset_n && (state == IDLE || state == FULL);
  // A request in the same cycle as clear is ignored; the board is being wiped.
  assign accept       = req_valid && req_ready && !clear;
  assign cnt_inc      = (r.count == FULL_CNT) ? r.count : r.count + 1'b1;

  // Next state and next register values. Pulses default to 0, state holds.
  always_comb begin
    nxt_state = state;
    n         = r;
    n.wr_en   = '0;
    n.illegal = 1'b0;
    n.code    = C_NONE;
`ifdef POS_WRITE_TURN_CHECK_EN
    nxt_exp_player = exp_player;
`endif
    if (clear) begin
      // A commit in flight has already pulsed wr_en. Its occupancy update is dropped here.
      nxt_state  = IDLE;
      n.occupied = '0;
      n.count    = '0;
      n.full     = 1'b0;
`ifdef POS_WRITE_TURN_CHECK_EN
      nxt_exp_player = 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            if (out_of_range) begin
              nxt_state = REJECT;
              n.illegal = 1'b1;
              n.code    = C_RANGE;
            end else if (|(dec & r.occupied)) begin
              nxt_state = REJECT;
              n.illegal = 1'b1;
              n.code    = C_OCC;
`ifdef POS_WRITE_TURN_CHECK_EN
            end else if (req_player != exp_player) begin
              nxt_state = REJECT;
              n.illegal = 1'b1;
              n.code    = C_TURN;
`endif
            end else begin
              nxt_state   = COMMIT;
              n.wr_en     = dec;
              n.wr_player = req_player;
            end
          end
        end
        COMMIT: begin
          // The write pulse is on the outputs now; record the move at the end of this cycle.
          n.occupied = r.occupied | r.wr_en;
          n.count    = cnt_inc;
          n.full     = (cnt_inc == FULL_CNT);
          nxt_state  = (cnt_inc == FULL_CNT) ? FULL : IDLE;
`ifdef POS_WRITE_TURN_CHECK_EN
          nxt_exp_player = ~exp_player;
`endif
        end
        REJECT: begin
          // After a reject, go back to whichever waiting state raised it.
          nxt_state = r.full ? FULL : IDLE;
        end
        FULL: begin
          if (accept) begin
            nxt_state = REJECT;
            n.illegal = 1'b1;
            n.code    = C_OCC;
          end
        end
        default: nxt_state = IDLE;
      endcase
    end
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state <= IDLE;
      r     <= '0;
    end else begin
      state <= nxt_state;
      r     <= n;
    end
  end

`ifdef POS_WRITE_TURN_CHECK_EN
  // Whose turn it is. Player 0 moves first after reset or clear.
  always_ff @(posedge clock) begin
    if (!reset_n) exp_player <= 1'b0;
    else          exp_player <= nxt_exp_player;
  end
`endif

  assign wr_en        = r.wr_en;
  assign wr_player    = r.wr_player;
  assign illegal      = r.illegal;
  assign illegal_code = r.code;
  assign occupied     = r.occupied;
  assign move_count   = r.count;
  assign board_full   = r.full;

endmodule
